// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and tag type for the multiplier-sharing arbiter
//
// Purpose: operand/result widths, default multiplier latency and the
//          {vld, id} tag that follows each product through the multiplier.
// Ports:   none (package).

package mult_pkg;

  localparam int MUL_W   = 4;
  localparam int RES_W   = 8;
  localparam int MUL_LAT = 4;
  localparam int ID_W    = 3;

  // Owner of one in-flight product; vld=0 marks an empty pipeline slot.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter with its own rotating pointer
//
// Purpose: picks the first asserted request starting at the pointer and
//          moving upward with wrap-around; the pointer moves past the winner.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   req_i         eligible requesters
//   advance_i     allow the pointer to move this cycle
//   gnt_o         one-hot grant (zero when nothing is requested)
//   gnt_id_o      index of the granted requester

module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_id_o
);

  logic [PW-1:0] rr_q, rr_d;
  logic          found;

  // Two passes: requesters at or above the pointer first, then the lowest
  // index overall. The second pass only fires when nothing at or above the
  // pointer asked, so it always lands below the pointer (the wrapped part).
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (PW'(i) >= rr_q)) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        gnt_id_o = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        gnt_id_o = PW'(i);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (advance_i && found) begin
      rr_d = (gnt_id_o == PW'(N - 1)) ? '0 : gnt_id_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - shares one fixed-latency multiplier among NREQ requesters
//
// Purpose: grants at most one operand pair per cycle (round-robin), follows
//          each product through the multiplier with a tag pipe, and returns it
//          to its owner through a per-requester valid/ready result slot.
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   req_valid_i/req_ready_o         operand handshake per requester
//   req_a_i/req_b_i                 4-bit operands, requester i at [4i+3:4i]
//   rsp_valid_o/rsp_ready_i         result handshake per requester
//   rsp_data_o                      8-bit products, requester i at [8i+7:8i]
//   issue_en_i                      gate for new grants
//   mul_data_rdy_o, mul_mult1_o/2_o drive the shared multiplier inputs
//   mul_res_rdy_i, mul_res_i        multiplier result
//   err_o                           sticky tag/result mismatch flag

module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = MUL_LAT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*MUL_W-1:0] req_a_i,
  input  logic [NREQ*MUL_W-1:0] req_b_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  input  logic [NREQ-1:0]       rsp_ready_i,
  output logic [NREQ*RES_W-1:0] rsp_data_o,
  input  logic                  issue_en_i,
  output logic                  mul_data_rdy_o,
  output logic [MUL_W-1:0]      mul_mult1_o,
  output logic [MUL_W-1:0]      mul_mult2_o,
  input  logic                  mul_res_rdy_i,
  input  logic [RES_W-1:0]      mul_res_i,
  output logic                  err_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       elig, gnt, hs, cap_1h;
  logic [NREQ-1:0]       busy_q, busy_d;
  logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [NREQ*RES_W-1:0] rsp_data_q;
  logic [IW-1:0]         gnt_id;
  logic                  any_gnt;
  logic                  err_q, err_d;
  tag_t                  tag_q [LAT];
  tag_t                  tag_in, tag_tail;

  // A requester with a product outstanding (in flight or parked in its slot)
  // is not eligible, so its slot is always free when the product returns.
  assign elig = req_valid_i & ~busy_q & {NREQ{issue_en_i}};

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (elig),
    .advance_i (issue_en_i),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id)
  );

  assign any_gnt        = |gnt;
  assign req_ready_o    = gnt;
  assign mul_data_rdy_o = any_gnt;

  always_comb begin
    mul_mult1_o = '0;
    mul_mult2_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mul_mult1_o = req_a_i[i*MUL_W +: MUL_W];
        mul_mult2_o = req_b_i[i*MUL_W +: MUL_W];
      end
    end
  end

  always_comb begin
    tag_in     = '0;
    tag_in.vld = any_gnt;
    tag_in.id  = ID_W'(gnt_id);
  end

  assign tag_tail = tag_q[LAT-1];

  // Capture only when the multiplier and the tag pipe agree a product is due.
  always_comb begin
    cap_1h = '0;
    for (int i = 0; i < NREQ; i++) begin
      cap_1h[i] = mul_res_rdy_i && tag_tail.vld && (tag_tail.id == ID_W'(i));
    end
  end

  assign hs          = rsp_valid_q & rsp_ready_i;
  assign rsp_valid_d = (rsp_valid_q & ~hs) | cap_1h;
  assign busy_d      = (busy_q | gnt) & ~hs;
  // Any disagreement between the multiplier and the tag pipe is fatal to
  // that product; it is dropped and the flag stays up until reset.
  assign err_d       = err_q | (mul_res_rdy_i != tag_tail.vld);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      for (int s = 0; s < LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      tag_q[0]    <= tag_in;
      for (int s = 1; s < LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
      for (int i = 0; i < NREQ; i++) begin
        if (cap_1h[i]) begin
          rsp_data_q[i*RES_W +: RES_W] <= mul_res_i;
        end
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - self-checking bench for mult_share_arbiter

module tb_mult_share_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int AW   = NREQ * 4;
  localparam int DW   = NREQ * 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [AW-1:0]   req_a = '0, req_b = '0;
  logic [DW-1:0]   rsp_data;
  logic            issue_en = 1'b1, inject = 1'b0;
  logic            mul_data_rdy, mul_res_rdy, err;
  logic [3:0]      mul_mult1, mul_mult2;
  logic [7:0]      mul_res;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_data_o     (rsp_data),
    .issue_en_i     (issue_en),
    .mul_data_rdy_o (mul_data_rdy),
    .mul_mult1_o    (mul_mult1),
    .mul_mult2_o    (mul_mult2),
    .mul_res_rdy_i  (mul_res_rdy),
    .mul_res_i      (mul_res),
    .err_o          (err)
  );

  // Behavioural pipelined multiplier, reset together with the DUT.
  logic       mp_v [LAT];
  logic [7:0] mp_p [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        mp_v[s] <= 1'b0;
        mp_p[s] <= 8'd0;
      end
    end else begin
      mp_v[0] <= mul_data_rdy;
      mp_p[0] <= {4'd0, mul_mult1} * {4'd0, mul_mult2};
      for (int s = 1; s < LAT; s++) begin
        mp_v[s] <= mp_v[s-1];
        mp_p[s] <= mp_p[s-1];
      end
    end
  end
  assign mul_res_rdy = mp_v[LAT-1] | inject;
  assign mul_res     = mp_p[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding-operation flags, pointer, result slots, and
  // a list of products due back at an absolute cycle number.
  logic [NREQ-1:0] m_busy = '0, m_rv = '0, s_hs;
  logic [7:0]      m_rd [NREQ];
  logic            m_err = 1'b0, s_rst, s_res, has;
  int              m_rr = 0, cyc = 0, w, idx;
  int              pq_due[$], pq_id[$];
  logic [7:0]      pq_p[$];
  logic [7:0]      s_prod;
  logic [NREQ-1:0] e_rdy;
  logic [3:0]      e_m1, e_m2;
  logic [DW-1:0]   e_rd;

  always begin
    @(negedge clk);
    if (rst) begin
      m_busy = '0; m_rv = '0; m_err = 1'b0; m_rr = 0;
      for (int i = 0; i < NREQ; i++) m_rd[i] = 8'd0;
      pq_due.delete(); pq_id.delete(); pq_p.delete();
    end
    w = -1;
    if (issue_en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (w < 0 && req_valid[idx] && !m_busy[idx]) w = idx;
      end
    end
    e_rdy = '0; e_m1 = 4'd0; e_m2 = 4'd0; s_prod = 8'd0;
    if (w >= 0) begin
      e_rdy[w] = 1'b1;
      e_m1 = req_a[w*4 +: 4];
      e_m2 = req_b[w*4 +: 4];
      s_prod = {4'd0, e_m1} * {4'd0, e_m2};
    end
    for (int i = 0; i < NREQ; i++) e_rd[i*8 +: 8] = m_rd[i];
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("mul_data_rdy", 32'(mul_data_rdy), 32'(w >= 0));
    chk("mul_mult1", 32'(mul_mult1), 32'(e_m1));
    chk("mul_mult2", 32'(mul_mult2), 32'(e_m2));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("rsp_data", rsp_data, e_rd);
    chk("err", 32'(err), 32'(m_err));
    s_rst = rst;
    s_res = mul_res_rdy;
    s_hs  = m_rv & rsp_ready;
    @(posedge clk);
    if (!s_rst) begin
      has = (pq_due.size() > 0) && (pq_due[0] == cyc);
      m_rv   = m_rv & ~s_hs;
      m_busy = m_busy & ~s_hs;
      if (s_res && has) begin
        m_rv[pq_id[0]] = 1'b1;
        m_rd[pq_id[0]] = pq_p[0];
      end
      if (s_res != has) m_err = 1'b1;
      if (has) begin
        void'(pq_due.pop_front()); void'(pq_id.pop_front()); void'(pq_p.pop_front());
      end
      if (w >= 0) begin
        m_busy[w] = 1'b1;
        m_rr = (w + 1) % NREQ;
        pq_due.push_back(cyc + LAT); pq_id.push_back(w); pq_p.push_back(s_prod);
      end
    end
    cyc++;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  logic [7:0]      fexp [NREQ];
  logic [NREQ-1:0] seen;
  int              gcount;

  initial begin
    fexp[0] = 8'd225; fexp[1] = 8'd0; fexp[2] = 8'd81; fexp[3] = 8'd48;
    repeat (2) cycle();
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_data_rdy", 32'(mul_data_rdy), 32'd0);
    do_reset();

    // Single request from requester 1: 3*5.
    rsp_ready = '0;
    cycle();
    req_valid = 4'b0010; req_a = 16'h0030; req_b = 16'h0050;
    @(negedge clk);
    chk("single_grant", 32'(req_ready), 32'b0010);
    chk("single_mult1", 32'(mul_mult1), 32'd3);
    cycle();
    req_valid = '0;
    repeat (3) cycle();
    @(negedge clk);
    chk("single_early", 32'(rsp_valid[1]), 32'd0);
    cycle();
    rsp_ready = 4'b0010;
    @(negedge clk);
    chk("single_valid", 32'(rsp_valid[1]), 32'd1);
    chk("single_data", 32'(rsp_data[15:8]), 32'd15);
    cycle();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("single_cleared", 32'(rsp_valid[1]), 32'd0);
    chk("single_reeligible", 32'(req_ready), 32'b0010);
    cycle();
    req_valid = '0; rsp_ready = '1;
    repeat (10) cycle();

    // Fairness from reset.
    do_reset();
    req_a = {4'd4, 4'd9, 4'd0, 4'd15};
    req_b = {4'd12, 4'd9, 4'd7, 4'd15};
    req_valid = '1; rsp_ready = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fair_grant", 32'(req_ready), 32'(4'b0001 << k));
      cycle();
    end
    for (int c = 4; c < 9; c++) begin
      @(negedge clk);
      if (c >= 5) begin
        chk("fair_slot_valid", 32'(rsp_valid[c-5]), 32'd1);
        chk("fair_slot_data", 32'(rsp_data[(c-5)*8 +: 8]), 32'(fexp[c-5]));
      end
      cycle();
    end
    req_valid = '0;
    repeat (12) cycle();

    // Backpressure on requester 2.
    req_valid = 4'b0100; req_a = 16'h0600; req_b = 16'h0700; rsp_ready = 4'b1011;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'b0100);
    gcount = 0;
    for (int c = 1; c < 25; c++) begin
      cycle();
      req_valid = (NREQ'($urandom) & 4'b1011) | 4'b0100;
      req_a = (AW'($urandom) & 16'hF0FF) | 16'h0600;
      req_b = (AW'($urandom) & 16'hF0FF) | 16'h0700;
      @(negedge clk);
      chk("bp_no_regrant", 32'(req_ready[2]), 32'd0);
      if (c >= 5) begin
        chk("bp_hold_valid", 32'(rsp_valid[2]), 32'd1);
        chk("bp_hold_data", 32'(rsp_data[23:16]), 32'd42);
      end
      if (req_ready != '0) gcount++;
    end
    chk("bp_others_granted", 32'(gcount > 0), 32'd1);
    cycle();
    req_valid = '0; rsp_ready = '1;
    repeat (12) cycle();

    // issue_en low with two products in flight.
    do_reset();
    req_a = AW'($urandom); req_b = AW'($urandom);
    req_valid = 4'b0011; rsp_ready = '1;
    @(negedge clk);
    chk("ie_grant0", 32'(req_ready), 32'b0001);
    cycle();
    @(negedge clk);
    chk("ie_grant1", 32'(req_ready), 32'b0010);
    cycle();
    issue_en = 1'b0; req_valid = '1; seen = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("ie_no_grant", 32'(req_ready), 32'd0);
      chk("ie_no_issue", 32'(mul_data_rdy), 32'd0);
      seen = seen | rsp_valid;
      cycle();
    end
    chk("ie_delivered", 32'(seen), 32'b0011);
    issue_en = 1'b1;
    @(negedge clk);
    chk("ie_resume_rr", 32'(req_ready), 32'b0100);
    cycle();
    req_valid = '0;
    repeat (12) cycle();

    // Reset with three products in flight.
    do_reset();
    req_valid = '1; rsp_ready = '1;
    repeat (3) cycle();
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    cycle();
    rst = 1'b0; req_valid = '1;
    @(negedge clk);
    chk("rst_first_grant", 32'(req_ready), 32'b0001);
    cycle();
    req_valid = '0;
    repeat (12) cycle();

    // Spurious result with an empty tag pipe.
    inject = 1'b1;
    cycle();
    inject = 1'b0;
    @(negedge clk);
    chk("perr_set", 32'(err), 32'd1);
    chk("perr_no_valid", 32'(rsp_valid), 32'd0);
    repeat (5) cycle();
    @(negedge clk);
    chk("perr_sticky", 32'(err), 32'd1);
    do_reset();
    @(negedge clk);
    chk("perr_cleared", 32'(err), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle();
      req_valid = NREQ'($urandom);
      req_a     = AW'($urandom);
      req_b     = AW'($urandom);
      rsp_ready = NREQ'($urandom);
      issue_en  = ($urandom_range(0, 7) != 0);
    end
    cycle();
    req_valid = '0; rsp_ready = '1; issue_en = 1'b1;
    repeat (12) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter that shares one `pipelined_multiplier` (4x4 unsigned, fixed latency, no stall) among `NREQ` requesters. It grants at most one operand pair per cycle and tracks the owner of each in-flight product with a tag shift register. Each product is returned to its owner through a per-requester result slot with a valid/ready handshake. The block sits between client engines and the shared multiplier instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `LAT`, 4: multiplier latency in cycles, from `data_rdy` high to `res_rdy` high.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: request i presents an operand pair.
- `req_ready` out NREQ: request i is granted this cycle; the transfer occurs when valid && ready.
- `req_a` in NREQ*4: multiplicand of requester i, bits [4i+3:4i].
- `req_b` in NREQ*4: multiplier of requester i, bits [4i+3:4i].
- `rsp_valid` out NREQ: result slot i holds an unconsumed product.
- `rsp_ready` in NREQ: requester i accepts its result.
- `rsp_data` out NREQ*8: product for requester i, bits [8i+7:8i].
- `issue_en` in 1: when low, no new grants; in-flight products still complete.
- `mul_data_rdy` out 1: drives the multiplier `data_rdy`.
- `mul_mult1` out 4: drives the multiplier `mult1`.
- `mul_mult2` out 4: drives the multiplier `mult2`.
- `mul_res_rdy` in 1: multiplier `res_rdy`.
- `mul_res` in 8: multiplier `res`.
- `err` out 1: sticky protocol-error flag.

## Operation
- **Eligibility.** Requester i is eligible when `req_valid[i]`, `busy[i]==0` and `issue_en` are all true.
- **`busy[i]`.**
  - Set on grant.
  - Cleared on the edge where `rsp_valid[i] && rsp_ready[i]`.
  - One outstanding operation per requester. This guarantees slot i is free when its product returns, so no result is ever dropped.
- **Arbitration.** Round-robin with pointer `rr` (log2 NREQ bits, reset 0).
  - Search order: `rr`, `rr+1`, … mod NREQ. The first eligible requester wins.
  - `req_ready` is one-hot or zero, and combinational from the registered state plus `req_valid`/`issue_en`.
  - On grant to w: `rr <= (w+1) mod NREQ`. With no grant, `rr` holds.
- **Issue path (combinational).**
  - `mul_data_rdy` = any grant.
  - `mul_mult1`/`mul_mult2` = winner's `req_a`/`req_b`.
  - Zero when there is no grant.
- **Tag pipe.** LAT-deep shift register of {vld, id}, reset all-zero.
  - Stage 0 loads {grant, w} every cycle.
  - Stage LAT-1 is compared with `mul_res_rdy`.
- **Capture.** When `mul_res_rdy` is high:
  - `rsp_data[id] <= mul_res`.
  - `rsp_valid[id] <= 1`.
  - `rsp_valid[i]` clears on handshake.
  - Capture and handshake never target the same slot in the same cycle, because of `busy`.
- **`err`.** Set, and held until `rst`, when `mul_res_rdy` differs from the tag vld at stage LAT-1. On error the product is discarded.
- **Reset values.** All outputs 0: `req_ready`, `rsp_valid`, `rsp_data`, `mul_*`, `err`.
  - Internal state also resets to 0: `busy`, `rr`, tag pipe.
  - Reset mid-operation abandons all in-flight products.
  - The multiplier must be reset by the same event; the integrator drives its `rstn` = ~`rst`.

## Timing
- **Grant.** A grant at cycle t means `mul_data_rdy` is high at t.
- **Latency.** `mul_res_rdy` is high at t+LAT, and `rsp_valid[w]` is high from t+LAT+1. Grant-to-response latency is LAT+1 cycles.
- **Throughput.** One grant per cycle across requesters.
- **Per-requester turnaround.**
  - A requester is re-eligible the cycle after its response handshake.
  - Minimum per-requester period is LAT+2 cycles when `rsp_ready` is held high.
- **Simultaneous events.**
  - Capture for slot j and a handshake on slot k≠j in the same cycle are both honoured.
  - A grant to i and a handshake on slot i cannot coincide, because `busy[i]` is still 1 during the handshake cycle.
- **`issue_en` low.** Takes effect the same cycle, combinationally; the `rr` pointer is frozen.

## Structure
- **Shared package `mult_pkg`:**
  - `MUL_W=4` and `RES_W=8`.
  - Default `MUL_LAT=4`.
  - Typedef `tag_t` = struct {vld, id[2:0]}.
- **Sub-module `rr_arbiter`:** parameter N; inputs `req[N]`, `advance`; output `gnt[N]` one-hot; owns the `rr` pointer.
- **Top-level contents:** `busy`, the tag pipe, result slots and `err`.
- **Multiplier instance:** not instantiated inside this block; it connects through the `mul_*` ports.

## Test plan
- **Single request.** Requester 1 sends a=3, b=5 at cycle 10 → `mul_data_rdy` at 10; `rsp_valid[1]` at 15 with `rsp_data[1]`=15; `busy` clears after handshake.
- **Fairness.** All 4 requesters hold valid with `rsp_ready`=1 from reset → grant order 0,1,2,3 on consecutive cycles. Products 15×15=225, 0×7=0, 9×9=81 and 4×12=48 are routed to the correct slots.
- **Backpressure.** Requester 2 holds `rsp_ready`=0 for 20 cycles after a=6, b=7 → `rsp_data[2]`=42 held stable, `req_ready[2]`=0 throughout, and the other requesters continue to be granted.
- **`issue_en`.** `issue_en` dropped for 5 cycles while 2 products are in flight → no grants, both products delivered, and `rr` unchanged on resume.
- **Reset mid-flight.** `rst` asserted with 3 products in flight → the next cycle shows `rsp_valid`=0, `busy`=0 and `err`=0; the first grant after release goes to requester 0.
- **Protocol error.** Inject a spurious `mul_res_rdy` with an empty tag pipe → `err`=1 and sticky, no `rsp_valid` change; `err` clears only on `rst`.
